tl_inflight_limiter: RTL



---
 rtl/tl_ul_pkg.sv | 42 ++++
 rtl/tl_inflight_limiter_if.sv | 14 +
 rtl/tl_inflight_ctr.sv | 38 +++
 rtl/tl_inflight_limiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// TileLink-UL shared definitions: opcodes, field widths and packed A/D channel payloads.
package tl_ul_pkg;

    localparam int unsigned TL_OPCODE_W  = 3;
    localparam int unsigned TL_A_PARAM_W = 3;
    localparam int unsigned TL_D_PARAM_W = 2;
    localparam int unsigned TL_SIZE_W    = 4;
    localparam int unsigned TL_SRC_W     = 5;
    localparam int unsigned TL_ADDR_W    = 32;
    localparam int unsigned TL_DATA_W    = 32;
    localparam int unsigned TL_MASK_W    = 4;
    localparam int unsigned TL_CNT_W     = 5;

    localparam logic [TL_OPCODE_W-1:0] A_GET             = 3'd4;
    localparam logic [TL_OPCODE_W-1:0] A_PUT_FULL        = 3'd0;
    localparam logic [TL_OPCODE_W-1:0] A_PUT_PARTIAL     = 3'd1;
    localparam logic [TL_OPCODE_W-1:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [TL_OPCODE_W-1:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [TL_OPCODE_W-1:0]  opcode;
        logic [TL_A_PARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]    size;
        logic [TL_SRC_W-1:0]     source;
        logic [TL_ADDR_W-1:0]    address;
        logic [TL_MASK_W-1:0]    mask;
        logic [TL_DATA_W-1:0]    data;
        logic                    corrupt;
    } a_chan_t;

    typedef struct packed {
        logic [TL_OPCODE_W-1:0]  opcode;
        logic [TL_D_PARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]    size;
        logic [TL_SRC_W-1:0]     source;
        logic                    sink;
        logic                    denied;
        logic [TL_DATA_W-1:0]    data;
        logic                    corrupt;
    } d_chan_t;

endpackage

// File: rtl/tl_inflight_limiter_if.sv
// One TileLink-UL link (A request + D response). The master modport issues A and accepts D.
interface tl_inflight_limiter_if;

    logic                 a_valid;
    logic                 a_ready;
    tl_ul_pkg::a_chan_t   a;
    logic                 d_valid;
    logic                 d_ready;
    tl_ul_pkg::d_chan_t   d;

    modport master (output a_valid, a, d_ready, input a_ready, d_valid, d);
    modport slave  (input a_valid, a, d_ready, output a_ready, d_valid, d);

endinterface

// File: rtl/tl_inflight_ctr.sv
// Saturating up/down outstanding-transaction counter with full compare against the limit.
module tl_inflight_ctr #(
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full_c
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Simultaneous inc/dec cancel; a decrement at zero saturates instead of wrapping.
    always_comb begin
        w_count_next = r_count;
        if (i_inc && !i_dec) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count  = r_count;
    assign o_full_c = (r_count >= CNT_W'(MAX_COUNT));

endmodule

// File: rtl/tl_inflight_limiter.sv
// TL-UL outstanding-request limiter with orphan-response detection.
// Define TL_INFLIGHT_SRC_BUSY_EN to also track per-source busy bits (blocks source reuse).
module tl_inflight_limiter
    import tl_ul_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned SRC_W        = TL_SRC_W
) (
    input  logic                  clock,
    input  logic                  reset,
    tl_inflight_limiter_if.slave  up,
    tl_inflight_limiter_if.master dn,
    output logic [TL_CNT_W-1:0]   inflight,
    output logic                  err_orphan,
    output logic [SRC_W-1:0]      err_source
);

    if (SRC_W != TL_SRC_W) begin : g_bad_src_w
        $error("SRC_W must match tl_ul_pkg::TL_SRC_W");
    end
    if ((MAX_INFLIGHT < 1) || (MAX_INFLIGHT > 31)) begin : g_bad_max
        $error("MAX_INFLIGHT must be in 1..31");
    end

    logic             w_full;
    logic             w_src_free;
    logic             w_d_matched;
    logic             w_a_gate;
    logic             w_a_fire;
    logic             w_d_fire;
    logic             w_orphan;
    logic             r_err_orphan;
    logic [SRC_W-1:0] r_err_source;

    // Gate depends only on registered state and the A source, never on D inputs.
    assign w_a_gate   = !w_full && w_src_free;

    assign dn.a_valid = up.a_valid && w_a_gate;
    assign dn.a       = up.a;
    assign up.a_ready = dn.a_ready && w_a_gate;

    assign up.d_valid = dn.d_valid;
    assign up.d       = dn.d;
    assign dn.d_ready = up.d_ready;

    assign w_a_fire = up.a_valid && up.a_ready;
    assign w_d_fire = dn.d_valid && dn.d_ready;
    assign w_orphan = w_d_fire && !w_d_matched;

    tl_inflight_ctr #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CNT_W     (TL_CNT_W)
    ) u_ctr (
        .clock    (clock),
        .reset    (reset),
        .i_inc    (w_a_fire),
        .i_dec    (w_d_fire),
        .o_count  (inflight),
        .o_full_c (w_full)
    );

`ifdef TL_INFLIGHT_SRC_BUSY_EN
    localparam int unsigned NUM_SRC = 1 << SRC_W;

    logic [NUM_SRC-1:0] r_busy;
    logic [NUM_SRC-1:0] w_busy_next;

    // Set after clear so a same-source request/response pair leaves the source busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_d_fire) begin
            w_busy_next[dn.d.source] = 1'b0;
        end
        if (w_a_fire) begin
            w_busy_next[up.a.source] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign w_src_free  = !r_busy[up.a.source];
    assign w_d_matched = r_busy[dn.d.source] && (inflight != '0);
`else
    assign w_src_free  = 1'b1;
    assign w_d_matched = (inflight != '0);
`endif

    // First orphan wins; the flag and captured source stay until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_orphan <= 1'b0;
            r_err_source <= '0;
        end else if (w_orphan && !r_err_orphan) begin
            r_err_orphan <= 1'b1;
            r_err_source <= SRC_W'(dn.d.source);
        end
    end

    assign err_orphan = r_err_orphan;
    assign err_source = r_err_source;

endmodule
